// File: rtl/permutation.sv
// permutation: streaming Keccak pi step, one 25-bit z-slice per transfer.
// Each slice is captured on a read cycle, lane-permuted combinationally and
// presented on the following ready cycle; 64 slices make up one state.
//
// state | meaning
// IDLE  | waiting for start, all flags low
// READ  | read=1, slice on 'in' captured at the closing edge
// OUT   | ready=1, 'out' holds the permuted slice
// DONE  | total_ready=1, held until start drops

module permutation (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [24:0] in,
    output logic        read,
    output logic        ready,
    output logic        total_ready,
    output logic [24:0] out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        OUT  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [6:0] SLICES = 7'd64;

    state_t      r_state;
    state_t      w_next;
    logic [24:0] r_s;
    logic [6:0]  r_cnt;
    logic [24:0] w_out;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Slice capture and slice counter; counter clears only once start drops in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s   <= '0;
            r_cnt <= '0;
        end else if (r_state == READ) begin
            r_s   <= in;
            r_cnt <= r_cnt + 7'd1;
        end else if ((r_state == DONE) && !start) begin
            r_cnt <= '0;
        end
    end

    // Next-state and flag decode.
    always_comb begin
        w_next      = r_state;
        read        = 1'b0;
        ready       = 1'b0;
        total_ready = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_next = READ;
            end
            READ: begin
                read   = 1'b1;
                w_next = OUT;
            end
            OUT: begin
                ready = 1'b1;
                if (r_cnt == SLICES) w_next = DONE;
                else                 w_next = READ;
            end
            DONE: begin
                total_ready = 1'b1;
                if (!start) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Lane permutation: out lane (x,y) takes S lane ((x+3y) mod 5, x).
    always_comb begin
        w_out = '0;
        for (int x = 0; x < 5; x++) begin
            for (int y = 0; y < 5; y++) begin
                w_out[5*y + x] = r_s[5*x + ((x + 3*y) % 5)];
            end
        end
    end

    assign out = w_out;

endmodule

// File: tb/tb_permutation.sv
// Directed bench for permutation with an expected-output queue.
module tb_permutation;

    logic        clk;
    logic        rst;
    logic        start;
    logic [24:0] in_s;
    logic        read;
    logic        ready;
    logic        total_ready;
    logic [24:0] out_s;

    int          checks = 0;
    int          errors = 0;
    logic [24:0] sb[$];
    logic [24:0] last_exp;

    permutation dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in          (in_s),
        .read        (read),
        .ready       (ready),
        .total_ready (total_ready),
        .out         (out_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Forward form: input lane (a,b) lands on output lane (b, 2(a-b) mod 5).
    function automatic logic [24:0] pi_model(input logic [24:0] v);
        logic [24:0] r;
        r = '0;
        for (int b = 0; b < 5; b++)
            for (int a = 0; a < 5; a++)
                r[5*((2*(a - b + 5)) % 5) + b] = v[5*b + a];
        return r;
    endfunction

    task automatic do_slice(input logic [24:0] v, input bit has_k, input logic [24:0] k);
        int          n;
        logic [24:0] e;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (read !== 1'b1 && n < 8);
        checks++;
        assert (read === 1'b1 && n == 1) else begin
            errors++;
            $error("FAIL read_latency got read=%b wait=%0d expected read=1 wait=1", read, n);
        end
        if (read !== 1'b1) return;
        checks++;
        assert (ready === 1'b0) else begin
            errors++;
            $error("FAIL ready_in_read got %b expected 0", ready);
        end
        in_s = v;
        sb.push_back(pi_model(v));
        @(negedge clk);
        in_s = $urandom;
        checks++;
        assert (ready === 1'b1 && read === 1'b0) else begin
            errors++;
            $error("FAIL ready_pulse got ready=%b read=%b expected ready=1 read=0", ready, read);
        end
        e = (sb.size() > 0) ? sb.pop_front() : 25'h0;
        last_exp = e;
        checks++;
        assert (out_s === e) else begin
            errors++;
            $error("FAIL out_ref got %h expected %h (in %h)", out_s, e, v);
        end
        if (has_k) begin
            checks++;
            assert (out_s === k) else begin
                errors++;
                $error("FAIL out_const got %h expected %h (in %h)", out_s, k, v);
            end
        end
    endtask

    task automatic run_random(input int n);
        for (int i = 0; i < n; i++) do_slice(25'($urandom), 1'b0, 25'h0);
    endtask

    task automatic check_done_hold(input int cycles);
        @(negedge clk);
        checks++;
        assert (total_ready === 1'b1 && ready === 1'b0 && read === 1'b0) else begin
            errors++;
            $error("FAIL total_rise got tr=%b ready=%b read=%b expected 1/0/0", total_ready, ready, read);
        end
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            checks++;
            assert (total_ready === 1'b1 && read === 1'b0 && out_s === last_exp) else begin
                errors++;
                $error("FAIL total_hold got tr=%b read=%b out=%h expected 1/0/%h", total_ready, read, out_s, last_exp);
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        in_s  = '0;
        last_exp = '0;

        // Reset state
        @(negedge clk);
        checks++;
        assert (read === 1'b0 && ready === 1'b0 && total_ready === 1'b0 && out_s === 25'h0) else begin
            errors++;
            $error("FAIL reset_state got rd=%b rdy=%b tr=%b out=%h expected 0/0/0/0", read, ready, total_ready, out_s);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            assert (read === 1'b0 && ready === 1'b0 && total_ready === 1'b0) else begin
                errors++;
                $error("FAIL idle_hold got rd=%b rdy=%b tr=%b expected 0/0/0", read, ready, total_ready);
            end
        end

        // Run 1: directed single-bit/all-ones/all-zeros slices, then random
        start = 1'b1;
        do_slice(25'h0000001, 1'b1, 25'h0000001);
        do_slice(25'h0000002, 1'b1, 25'h0000400);
        do_slice(25'h0000020, 1'b1, 25'h0010000);
        do_slice(25'h1FFFFFF, 1'b1, 25'h1FFFFFF);
        do_slice(25'h0000000, 1'b1, 25'h0000000);
        run_random(59);
        check_done_hold(3);

        // Re-arm: drop start for one edge, total_ready must fall
        start = 1'b0;
        @(negedge clk);
        checks++;
        assert (total_ready === 1'b0 && read === 1'b0) else begin
            errors++;
            $error("FAIL rearm got tr=%b read=%b expected 0/0", total_ready, read);
        end

        // Run 2: back-to-back state
        start = 1'b1;
        run_random(64);
        check_done_hold(1);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;

        // Run 3: reset during slice 30
        run_random(29);
        @(negedge clk);
        checks++;
        assert (read === 1'b1) else begin
            errors++;
            $error("FAIL slice30_read got %b expected 1", read);
        end
        in_s = 25'($urandom) | 25'h1;
        #2 rst = 1'b1;
        #1;
        checks++;
        assert (read === 1'b0 && ready === 1'b0 && total_ready === 1'b0 && out_s === 25'h0) else begin
            errors++;
            $error("FAIL async_reset got rd=%b rdy=%b tr=%b out=%h expected 0/0/0/0", read, ready, total_ready, out_s);
        end
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            assert (read === 1'b0 && ready === 1'b0 && total_ready === 1'b0) else begin
                errors++;
                $error("FAIL post_reset_quiet got rd=%b rdy=%b tr=%b expected 0/0/0", read, ready, total_ready);
            end
        end

        // Run 4: fresh full run after the abandoned one
        start = 1'b1;
        run_random(64);
        check_done_hold(2);
        start = 1'b0;
        @(negedge clk);

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_left got %0d expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
